// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs exchanged between the stopwatch panel and its control FSM.
interface stopwatch_ctrl_if;
  logic       start_stop_btn;
  logic       lap_btn;
  logic       clear_btn;
  logic       enable;
  logic       clear_cnt;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    output start_stop_btn, lap_btn, clear_btn,
    input  enable, clear_cnt, lap_hold, state
  );

  modport slave (
    input  start_stop_btn, lap_btn, clear_btn,
    output enable, clear_cnt, lap_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronises and debounces three push-buttons, converts them to press
// events and drives the counter enable, counter clear pulse and display lap hold.
module stopwatch_ctrl #(
  parameter int unsigned DB_CYCLES = 3,
  parameter int unsigned DB_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned NBTN    = 3;
  localparam int unsigned BTN_SS  = 0;
  localparam int unsigned BTN_LAP = 1;
  localparam int unsigned BTN_CLR = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_e;

  logic [NBTN-1:0] sync1_q, sync1_d;
  logic [NBTN-1:0] sync2_q, sync2_d;
  logic [NBTN-1:0] db_level_q, db_level_d;
  logic [NBTN-1:0] db_prev_q, db_prev_d;
  logic [DB_W-1:0] db_cnt_q [NBTN];
  logic [DB_W-1:0] db_cnt_d [NBTN];
  logic [NBTN-1:0] ev_c;

  state_e state_q, state_d;
  logic   enable_q, enable_d;
  logic   lap_hold_q, lap_hold_d;
  logic   clear_cnt_q, clear_cnt_d;

  // Input path: two-flop synchroniser, debounce counter, rising-edge press detect
  always_comb begin
    sync1_d    = {bus.clear_btn, bus.lap_btn, bus.start_stop_btn};
    sync2_d    = sync1_q;
    db_prev_d  = db_level_q;
    db_level_d = db_level_q;
    for (int unsigned i = 0; i < NBTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_level_d[i] = ~db_level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
    ev_c = db_level_q & ~db_prev_q;
  end

  // Control FSM: one event per cycle, start_stop > clear > lap
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = 1'b0;
    if (ev_c[BTN_SS]) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = STOP;
        LAP:     state_d = STOP;
        STOP:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (ev_c[BTN_CLR]) begin
      if (state_q == IDLE || state_q == STOP) begin
        state_d     = IDLE;
        clear_cnt_d = 1'b1;
      end
    end else if (ev_c[BTN_LAP]) begin
      if (state_q == RUN) begin
        state_d = LAP;
      end else if (state_q == LAP) begin
        state_d = RUN;
      end
    end
    enable_d   = (state_d == RUN) || (state_d == LAP);
    lap_hold_d = (state_d == LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_level_q  <= '0;
      db_prev_q   <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      lap_hold_q  <= 1'b0;
      clear_cnt_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_prev_d;
      for (int unsigned i = 0; i < NBTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q     <= state_d;
      enable_q    <= enable_d;
      lap_hold_q  <= lap_hold_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.enable    = enable_q;
  assign bus.lap_hold  = lap_hold_q;
  assign bus.clear_cnt = clear_cnt_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: reset, debounce latency, glitch rejection, FSM sequence,
// event arbitration and ignored events.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;
  localparam logic [1:0] S_LAP  = 2'b11;

  localparam logic [2:0] B_SS  = 3'b001;
  localparam logic [2:0] B_LAP = 3'b010;
  localparam logic [2:0] B_CLR = 3'b100;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   clr_seen;
  int   lap_seen;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DB_CYCLES(3), .DB_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one edge, sample 1ns later, and tally pulse activity
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.clear_cnt === 1'b1) clr_seen++;
    if (bus.lap_hold === 1'b1) lap_seen++;
  endtask

  task automatic set_btns(input logic [2:0] m);
    bus.start_stop_btn = m[0];
    bus.lap_btn        = m[1];
    bus.clear_btn      = m[2];
  endtask

  task automatic do_reset();
    set_btns(3'b000);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Hold the buttons in mask for n cycles, release, then let everything settle
  task automatic press(input logic [2:0] m, input int n);
    clr_seen = 0;
    lap_seen = 0;
    set_btns(m);
    for (int i = 0; i < n; i++) tick();
    set_btns(3'b000);
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_btns(3'b111);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.state !== S_IDLE) begin
        failures++; $display("FAIL reset_state: got %b expected %b", bus.state, S_IDLE);
      end
      checks++;
      if (bus.enable !== 1'b0) begin
        failures++; $display("FAIL reset_enable: got %b expected 0", bus.enable);
      end
      checks++;
      if (bus.clear_cnt !== 1'b0) begin
        failures++; $display("FAIL reset_clear_cnt: got %b expected 0", bus.clear_cnt);
      end
      checks++;
      if (bus.lap_hold !== 1'b0) begin
        failures++; $display("FAIL reset_lap_hold: got %b expected 0", bus.lap_hold);
      end
    end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    set_btns(B_SS);
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (bus.state !== S_IDLE || bus.enable !== 1'b0) begin
        failures++;
        $display("FAIL latency_early: edge %0d state=%b enable=%b expected 00/0", e, bus.state, bus.enable);
      end
    end
    tick();
    checks++;
    if (bus.state !== S_RUN || bus.enable !== 1'b1) begin
      failures++;
      $display("FAIL latency_edge5: state=%b enable=%b expected 01/1", bus.state, bus.enable);
    end
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (bus.state !== S_RUN) begin
        failures++; $display("FAIL latency_hold: cycle %0d state=%b expected 01", e, bus.state);
      end
    end
    set_btns(3'b000);
    for (int e = 0; e < 10; e++) tick();
    checks++;
    if (bus.state !== S_RUN) begin
      failures++; $display("FAIL latency_release: state=%b expected 01", bus.state);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    press(B_SS, 2);
    checks++;
    if (bus.state !== S_IDLE) begin
      failures++; $display("FAIL glitch_2cyc: state=%b expected 00", bus.state);
    end
    press(B_SS, 4);
    checks++;
    if (bus.state !== S_RUN) begin
      failures++; $display("FAIL glitch_4cyc: state=%b expected 01", bus.state);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    press(B_SS, 5);
    checks++;
    if (bus.state !== S_RUN || bus.enable !== 1'b1 || bus.lap_hold !== 1'b0) begin
      failures++;
      $display("FAIL seq_run1: state=%b en=%b lh=%b expected 01/1/0", bus.state, bus.enable, bus.lap_hold);
    end
    press(B_LAP, 5);
    checks++;
    if (bus.state !== S_LAP || bus.enable !== 1'b1 || bus.lap_hold !== 1'b1) begin
      failures++;
      $display("FAIL seq_lap: state=%b en=%b lh=%b expected 11/1/1", bus.state, bus.enable, bus.lap_hold);
    end
    press(B_LAP, 5);
    checks++;
    if (bus.state !== S_RUN || bus.enable !== 1'b1 || bus.lap_hold !== 1'b0) begin
      failures++;
      $display("FAIL seq_run2: state=%b en=%b lh=%b expected 01/1/0", bus.state, bus.enable, bus.lap_hold);
    end
    press(B_SS, 5);
    checks++;
    if (bus.state !== S_STOP || bus.enable !== 1'b0 || bus.lap_hold !== 1'b0) begin
      failures++;
      $display("FAIL seq_stop: state=%b en=%b lh=%b expected 10/0/0", bus.state, bus.enable, bus.lap_hold);
    end
    press(B_CLR, 5);
    checks++;
    if (bus.state !== S_IDLE || bus.enable !== 1'b0) begin
      failures++; $display("FAIL seq_idle: state=%b en=%b expected 00/0", bus.state, bus.enable);
    end
    checks++;
    if (clr_seen !== 1) begin
      failures++; $display("FAIL seq_clear_pulse: got %0d cycles expected 1", clr_seen);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(B_SS, 5);
    press(B_SS | B_LAP, 5);
    checks++;
    if (bus.state !== S_STOP) begin
      failures++; $display("FAIL simul_ss_lap: state=%b expected 10", bus.state);
    end
    checks++;
    if (lap_seen !== 0) begin
      failures++; $display("FAIL simul_lap_hold: got %0d cycles expected 0", lap_seen);
    end
    press(B_CLR | B_LAP, 5);
    checks++;
    if (bus.state !== S_IDLE || clr_seen !== 1) begin
      failures++; $display("FAIL simul_clr_lap: state=%b pulses=%0d expected 00/1", bus.state, clr_seen);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    press(B_LAP, 5);
    checks++;
    if (bus.state !== S_IDLE || lap_seen !== 0) begin
      failures++; $display("FAIL ign_lap_idle: state=%b lh=%0d expected 00/0", bus.state, lap_seen);
    end
    press(B_SS, 5);
    press(B_CLR, 5);
    checks++;
    if (bus.state !== S_RUN || clr_seen !== 0) begin
      failures++; $display("FAIL ign_clr_run: state=%b pulses=%0d expected 01/0", bus.state, clr_seen);
    end
    press(B_LAP, 5);
    press(B_CLR, 5);
    checks++;
    if (bus.state !== S_LAP || clr_seen !== 0) begin
      failures++; $display("FAIL ign_clr_lap: state=%b pulses=%0d expected 11/0", bus.state, clr_seen);
    end
    press(B_SS, 5);
    press(B_LAP, 5);
    checks++;
    if (bus.state !== S_STOP || lap_seen !== 0) begin
      failures++; $display("FAIL ign_lap_stop: state=%b lh=%0d expected 10/0", bus.state, lap_seen);
    end
    press(B_SS, 5);
    press(B_LAP, 5);
    checks++;
    if (bus.state !== S_LAP) begin
      failures++; $display("FAIL ign_setup_lap: state=%b expected 11", bus.state);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.state !== S_IDLE || bus.clear_cnt !== 1'b0 || bus.lap_hold !== 1'b0 || bus.enable !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_lap: state=%b clr=%b lh=%b en=%b expected 00/0/0/0",
               bus.state, bus.clear_cnt, bus.lap_hold, bus.enable);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr_seen = 0;
    lap_seen = 0;
    rst      = 1'b1;
    set_btns(3'b000);
    test_reset();
    test_latency();
    test_glitch();
    test_sequence();
    test_simultaneous();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
